fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output reorder stage that sits directly downstream of the last R2SDF butterfly stage (stage n=N).
- The butterfly chain emits one complex sample per clock in bit-reversed frequency order. This block buffers each 2^N-sample frame in a ping-pong RAM and re-emits it in natural order, one sample per clock.
- It consumes the last stage's op/start_op pair and regenerates an equivalent start_op pulse for the next consumer.

Parameters:
- N, 3: log2 of FFT size; frame length L = 2^N; legal range 1..12.
- W, 32: width of each real/imag component (two's complement, Q16.16 in fixed-point builds); passed through unmodified.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- start_ip, input, 1: single-cycle pulse, high in the same cycle as frame sample 0 (driven by upstream start_op).
- ip_re, input, W: real part of current input sample.
- ip_im, input, W: imaginary part of current input sample.
- op_re, output, W: real part of reordered output sample (registered).
- op_im, output, W: imaginary part of reordered output sample (registered).
- op_valid, output, 1: high while op_re/op_im carry a frame sample.
- start_op, output, 1: single-cycle pulse coincident with natural-order sample 0.
- frame_err, output, 1: single-cycle pulse when a frame is aborted by an early start_ip.

Behaviour:
- Reset state: all outputs 0, wr_bank=0, wr_active=0, rd_active=0, all counters 0. RAM contents are don't-care.
- Storage: two banks of L complex words each.
- Write side:
  - start_ip sampled high at edge t0 captures sample k=0. Samples k=1..L-1 are captured unconditionally at edges t0+k; input is continuous, with no stall.
  - Sample k is written to address bitrev_N(k) of bank wr_bank.
  - wr_cnt is N bits. After k=L-1 is written: wr_bank toggles, the read side is armed on the just-filled bank, and wr_active drops unless start_ip arrives on that same edge.
  - Samples presented while wr_active=0 and start_ip=0 are ignored.
- Read side:
  - Once armed at edge t0+L-1, the registered output at edge t0+L+j (j=0..L-1) carries address j of the filled bank.
  - Latency: sample-0 capture to first output register update is exactly L edges.
  - op_valid=1 for those L cycles. start_op=1 only with j=0.
  - After j=L-1, op_valid falls next edge and op_re/op_im hold their last value, unless a new read is armed.
- Back-to-back frames: start_ip at edge t0+L is legal.
  - The new frame writes the other bank while the previous bank is read.
  - Output is gapless: the next frame's j=0 follows the previous j=L-1 directly, with start_op re-pulsed.
  - A read and a write never target the same bank in the same cycle.
- Early start_ip (wr_active=1 and wr_cnt!=0 when start_ip is sampled):
  - The partial frame is discarded and frame_err pulses for 1 cycle.
  - The write restarts at k=0 in the same wr_bank.
  - An in-progress read of the other bank continues unaffected.
- start_ip on the exact edge of k=L-1: not an overlap. The frame completes normally and the new frame starts in the toggled bank.
- Reset asserted mid-frame or mid-read: immediate return to the reset state, no output pulses. The first frame after deassertion behaves as a cold start.
- N=1: bitrev is identity; latency is 2.
- Data path carries no arithmetic; bits pass through exactly.

Test Plan:
- N=3, single frame, ip_re=k, ip_im=-k for k=0..7 from t0 -> output at t0+8..t0+15: re = 0,4,2,6,1,5,3,7; im = negatives of those; start_op only at t0+8; op_valid exactly 8 cycles.
- N=3, two back-to-back frames (second start_ip at t0+8, values 100+k) -> 16 contiguous valid cycles; second block is 100,104,102,106,101,105,103,107; start_op at t0+8 and t0+16.
- N=3, start_ip again at k=5 -> frame_err pulse; no output from the aborted frame; the restarted frame produces the correct 8-sample permutation 8 cycles after restart.
- Reset asserted at read cycle j=3 -> op_valid, start_op, op_re/op_im all 0 same cycle; no stale output after release; a fresh frame reorders correctly.
- N=4, random full-scale W-bit values incl. 0x8000_0000 and 0x7FFF_FFFF -> output equals scoreboard bit-reverse permutation bit-exactly.
- N=1 -> inputs a,b yield outputs a,b with latency 2; start_op on a.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reorder stage for an R2SDF FFT. The final butterfly stage emits one
// complex sample per clock in bit-reversed frequency order. Each 2^N-sample
// frame is written into one half of a ping-pong RAM at its bit-reversed
// address. The frame is then read back in natural order, one sample per
// clock, while the next frame fills the other half.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start_ip   one-cycle pulse that marks input sample 0 of a frame
//   ip_re/im   current input sample, W bits each
//   op_re/im   registered output sample in natural order
//   op_valid   high while op_re/op_im carry a frame sample
//   start_op   one-cycle pulse that marks output sample 0
//   frame_err  one-cycle pulse when a partial frame is dropped by an early
//              start_ip
// ---------------------------------------------------------------------------
module fft_bitrev_reorder #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_ip,
    input  logic [W-1:0] ip_re,
    input  logic [W-1:0] ip_im,
    output logic [W-1:0] op_re,
    output logic [W-1:0] op_im,
    output logic         op_valid,
    output logic         start_op,
    output logic         frame_err
);
    localparam int           L        = 1 << N;
    localparam logic [N-1:0] LAST_IDX = '1;
    localparam logic [N-1:0] ONE      = 1;

    // Both banks live in one array. The bank bit is the address MSB.
    logic [2*W-1:0] ram [2*L];

    logic         wr_bank_reg, wr_bank_next;
    logic         wr_active_reg, wr_active_next;
    logic [N-1:0] wr_cnt_reg, wr_cnt_next;
    logic         rd_bank_reg, rd_bank_next;
    logic         rd_active_reg, rd_active_next;
    logic [N-1:0] rd_cnt_reg, rd_cnt_next;
    logic         frame_err_next;

    logic [W-1:0] op_re_reg, op_im_reg;
    logic         op_valid_reg, start_op_reg, frame_err_reg;

    logic         wr_last;
    logic         wr_en;
    logic [N-1:0] wr_k;
    logic [N-1:0] wr_addr;

    // Next-state logic for the write and read controllers.
    always_comb begin
        wr_last        = wr_active_reg && (wr_cnt_reg == LAST_IDX);
        wr_en          = wr_active_reg || start_ip;
        // start_ip restarts at k=0. The exception is the final sample of a
        // frame: that sample still completes the current frame.
        wr_k           = (start_ip && !wr_last) ? '0 : wr_cnt_reg;

        wr_bank_next   = wr_bank_reg;
        wr_active_next = wr_active_reg;
        wr_cnt_next    = wr_cnt_reg;
        rd_bank_next   = rd_bank_reg;
        rd_active_next = rd_active_reg;
        rd_cnt_next    = rd_cnt_reg;
        frame_err_next = 1'b0;

        if (wr_last) begin
            // The frame is complete. Hand the bank to the reader and flip to
            // the other bank. A start_ip on this edge keeps the writer armed,
            // so the next sample becomes k=0 in the new bank.
            wr_bank_next   = ~wr_bank_reg;
            wr_active_next = start_ip;
            wr_cnt_next    = '0;
        end else if (start_ip) begin
            frame_err_next = wr_active_reg && (wr_cnt_reg != '0);
            wr_active_next = 1'b1;
            wr_cnt_next    = ONE;
        end else if (wr_active_reg) begin
            wr_cnt_next    = wr_cnt_reg + ONE;
        end

        // Completions are at least L edges apart. Arming therefore happens
        // only when the reader is idle or is emitting its last sample, which
        // keeps the output gapless.
        if (wr_last) begin
            rd_active_next = 1'b1;
            rd_bank_next   = wr_bank_reg;
            rd_cnt_next    = '0;
        end else if (rd_active_reg) begin
            rd_cnt_next = rd_cnt_reg + ONE;
            if (rd_cnt_reg == LAST_IDX) begin
                rd_active_next = 1'b0;
            end
        end
    end

    // Bit-reverse the write index to form the RAM address.
    for (genvar gi = 0; gi < N; gi++) begin : g_bitrev
        assign wr_addr[gi] = wr_k[N-1-gi];
    end

    // RAM write port. The contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[{wr_bank_reg, wr_addr}] <= {ip_re, ip_im};
        end
    end

    // Control state. The output register is also the RAM read register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_reg   <= 1'b0;
            wr_active_reg <= 1'b0;
            wr_cnt_reg    <= '0;
            rd_bank_reg   <= 1'b0;
            rd_active_reg <= 1'b0;
            rd_cnt_reg    <= '0;
            op_re_reg     <= '0;
            op_im_reg     <= '0;
            op_valid_reg  <= 1'b0;
            start_op_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            wr_bank_reg   <= wr_bank_next;
            wr_active_reg <= wr_active_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_bank_reg   <= rd_bank_next;
            rd_active_reg <= rd_active_next;
            rd_cnt_reg    <= rd_cnt_next;
            op_valid_reg  <= rd_active_reg;
            start_op_reg  <= rd_active_reg && (rd_cnt_reg == '0);
            frame_err_reg <= frame_err_next;
            // When no read is active, the output holds its last value.
            if (rd_active_reg) begin
                {op_re_reg, op_im_reg} <= ram[{rd_bank_reg, rd_cnt_reg}];
            end
        end
    end

    assign op_re     = op_re_reg;
    assign op_im     = op_im_reg;
    assign op_valid  = op_valid_reg;
    assign start_op  = start_op_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Drives one shared input stream into three instances of the reorder stage,
// with N=3, N=4 and N=1. A frame-level reference model tracks each instance.
// The model collects the input samples of each frame in natural index order.
// When a frame completes, it schedules that frame's natural-order output,
// sample j = frame[bitrev(j)], starting on the following edge.
// Directed checks against hand-computed permutations are added on top.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;
    localparam int W  = 32;
    localparam int NI = 3;
    localparam int HC = 1024;

    logic         clk;
    logic         reset;
    logic         start_ip;
    logic [W-1:0] ip_re, ip_im;
    logic [W-1:0] o_re [NI];
    logic [W-1:0] o_im [NI];
    logic         o_valid [NI];
    logic         o_start [NI];
    logic         o_err [NI];

    int nlog [NI] = '{3, 4, 1};
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state (per instance)
    bit           m_act [NI];
    int           m_cnt [NI];
    logic [W-1:0] mb_re [NI][16];
    logic [W-1:0] mb_im [NI][16];
    logic [W-1:0] ob_re [NI][16];
    logic [W-1:0] ob_im [NI][16];
    int           o_base [NI];
    logic [W-1:0] e_re [NI];
    logic [W-1:0] e_im [NI];
    bit           e_valid [NI];
    bit           e_start [NI];
    bit           e_err [NI];

    // Observed history, indexed by edge number
    logic [W-1:0] h_re [NI][HC];
    logic [W-1:0] h_im [NI][HC];
    logic         h_v [NI][HC];
    logic         h_s [NI][HC];
    logic         h_e [NI][HC];

    int perm3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_reorder #(.N(3), .W(W)) u_n3 (
        .clk(clk), .reset(reset), .start_ip(start_ip), .ip_re(ip_re), .ip_im(ip_im),
        .op_re(o_re[0]), .op_im(o_im[0]), .op_valid(o_valid[0]),
        .start_op(o_start[0]), .frame_err(o_err[0]));

    fft_bitrev_reorder #(.N(4), .W(W)) u_n4 (
        .clk(clk), .reset(reset), .start_ip(start_ip), .ip_re(ip_re), .ip_im(ip_im),
        .op_re(o_re[1]), .op_im(o_im[1]), .op_valid(o_valid[1]),
        .start_op(o_start[1]), .frame_err(o_err[1]));

    fft_bitrev_reorder #(.N(1), .W(W)) u_n1 (
        .clk(clk), .reset(reset), .start_ip(start_ip), .ip_re(ip_re), .ip_im(ip_im),
        .op_re(o_re[2]), .op_im(o_im[2]), .op_valid(o_valid[2]),
        .start_op(o_start[2]), .frame_err(o_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bitrev(input int x, input int n);
        int r = 0;
        for (int b = 0; b < n; b++) r = (r << 1) | ((x >> b) & 1);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_act[i]   = 1'b0;
            m_cnt[i]   = 0;
            o_base[i]  = -100000;
            e_re[i]    = '0;
            e_im[i]    = '0;
            e_valid[i] = 1'b0;
            e_start[i] = 1'b0;
            e_err[i]   = 1'b0;
        end
    endfunction

    // Advance instance i by one clock edge with the given input sample.
    function automatic void model_step(input int i, input bit st,
                                       input logic [W-1:0] re, input logic [W-1:0] im);
        int len = 1 << nlog[i];
        int j   = cyc - o_base[i];
        if (j >= 0 && j < len) begin
            e_valid[i] = 1'b1;
            e_start[i] = (j == 0);
            e_re[i]    = ob_re[i][j];
            e_im[i]    = ob_im[i][j];
        end else begin
            e_valid[i] = 1'b0;
            e_start[i] = 1'b0;
        end
        e_err[i] = 1'b0;
        if (m_act[i] && m_cnt[i] == len - 1) begin
            mb_re[i][len-1] = re;
            mb_im[i][len-1] = im;
            for (int k = 0; k < len; k++) begin
                ob_re[i][k] = mb_re[i][bitrev(k, nlog[i])];
                ob_im[i][k] = mb_im[i][bitrev(k, nlog[i])];
            end
            o_base[i] = cyc + 1;
            m_act[i]  = st;
            m_cnt[i]  = 0;
        end else if (st) begin
            e_err[i]    = m_act[i] && (m_cnt[i] != 0);
            mb_re[i][0] = re;
            mb_im[i][0] = im;
            m_cnt[i]    = 1;
            m_act[i]    = 1'b1;
        end else if (m_act[i]) begin
            mb_re[i][m_cnt[i]] = re;
            mb_im[i][m_cnt[i]] = im;
            m_cnt[i]++;
        end
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, step model at posedge, compare at negedge.
    task automatic cycle(input bit st, input logic [W-1:0] re, input logic [W-1:0] im);
        logic [2*W+2:0] obs, exp;
        start_ip = st;
        ip_re    = re;
        ip_im    = im;
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i, st, re, im);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            h_re[i][cyc] = o_re[i];
            h_im[i][cyc] = o_im[i];
            h_v[i][cyc]  = o_valid[i];
            h_s[i][cyc]  = o_start[i];
            h_e[i][cyc]  = o_err[i];
            obs = {o_valid[i], o_start[i], o_err[i], o_re[i], o_im[i]};
            exp = {e_valid[i], e_start[i], e_err[i], e_re[i], e_im[i]};
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL model_n%0d edge %0d: observed v/s/e/re/im=%h expected %h",
                       nlog[i], cyc, obs, exp);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, $urandom, $urandom);
    endtask

    task automatic check_zero(input string tag);
        logic [2*W+2:0] obs;
        for (int i = 0; i < NI; i++) begin
            obs = {o_valid[i], o_start[i], o_err[i], o_re[i], o_im[i]};
            checks++;
            assert (obs === {(2*W+3){1'b0}}) else begin
                errors++;
                $error("FAIL %s_n%0d: observed %h expected all zero", tag, nlog[i], obs);
            end
        end
    endtask

    initial begin
        int t0, t1, tr, te;
        logic [W-1:0] f0_re [16];
        logic [W-1:0] a_re, b_re;

        reset    = 1'b1;
        start_ip = 1'b0;
        ip_re    = '0;
        ip_im    = '0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_zero("reset_state");
        end
        reset = 1'b0;

        // A: single N=3 frame, re=k, im=-k
        t0 = cyc;
        for (int k = 0; k < 8; k++) cycle(k == 0, W'(k), W'(-k));
        idle(40);
        chk("A_valid_before", W'(h_v[0][t0+7]), '0);
        chk("A_valid_after", W'(h_v[0][t0+16]), '0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("A_re%0d", j), h_re[0][t0+8+j], W'(perm3[j]));
            chk($sformatf("A_im%0d", j), h_im[0][t0+8+j], W'(-perm3[j]));
            chk($sformatf("A_start%0d", j), W'(h_s[0][t0+8+j]), W'(j == 0));
            chk($sformatf("A_valid%0d", j), W'(h_v[0][t0+8+j]), W'(1));
        end

        // B: two back-to-back N=3 frames
        t0 = cyc;
        for (int k = 0; k < 8; k++) cycle(k == 0, W'(k), W'(-k));
        for (int k = 0; k < 8; k++) cycle(k == 0, W'(100 + k), W'(-(100 + k)));
        idle(40);
        for (int j = 0; j < 16; j++) chk($sformatf("B_valid%0d", j), W'(h_v[0][t0+8+j]), W'(1));
        chk("B_valid_end", W'(h_v[0][t0+24]), '0);
        chk("B_start_first", W'(h_s[0][t0+8]), W'(1));
        chk("B_start_second", W'(h_s[0][t0+16]), W'(1));
        chk("B_start_mid", W'(h_s[0][t0+9]), '0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("B_re2_%0d", j), h_re[0][t0+16+j], W'(100 + perm3[j]));

        // C: early restart at k=5
        t0 = cyc;
        for (int k = 0; k < 5; k++) cycle(k == 0, W'(50 + k), W'(k));
        tr = cyc;
        for (int k = 0; k < 8; k++) cycle(k == 0, W'(200 + k), W'(-(200 + k)));
        idle(40);
        chk("C_frame_err", W'(h_e[0][tr]), W'(1));
        chk("C_frame_err_len", W'(h_e[0][tr+1]), '0);
        chk("C_no_abort_out", W'(h_v[0][tr+7]), '0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("C_re%0d", j), h_re[0][tr+8+j], W'(200 + perm3[j]));

        // D: reset during read sample j=3, then a fresh frame
        t0 = cyc;
        for (int k = 0; k < 8; k++) cycle(k == 0, W'(300 + k), W'(k));
        idle(4);
        chk("D_valid_j3", W'(h_v[0][t0+11]), W'(1));
        chk("D_re_j3", h_re[0][t0+11], W'(306));
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_hold");
        reset = 1'b0;
        model_reset();
        cyc++;
        t1 = cyc;
        idle(3);
        for (int k = 0; k < 8; k++) cycle(k == 0, W'(400 + k), W'(-k));
        idle(40);
        chk("D_no_stale", W'(h_v[0][t1]), '0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("D_re%0d", j), h_re[0][t1+3+8+j], W'(400 + perm3[j]));

        // E: three back-to-back N=4 frames with random full-scale data
        te = cyc;
        a_re = '0;
        b_re = '0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) begin
                logic [W-1:0] r, m;
                r = $urandom;
                m = $urandom;
                if (k == 3) begin r = 32'h8000_0000; m = 32'h7FFF_FFFF; end
                if (k == 9) begin r = 32'h7FFF_FFFF; m = 32'h8000_0000; end
                if (f == 0) f0_re[k] = r;
                if (f == 0 && k == 0) a_re = r;
                if (f == 0 && k == 1) b_re = r;
                cycle(k == 0, r, m);
            end
        end
        idle(40);
        for (int j = 0; j < 16; j++)
            chk($sformatf("E_n4_re%0d", j), h_re[1][te+16+j], f0_re[bitrev(j, 4)]);
        chk("E_n4_start", W'(h_s[1][te+16]), W'(1));
        chk("E_n4_gapless", W'(h_v[1][te+32]), W'(1));
        chk("E_n1_a", h_re[2][te+2], a_re);
        chk("E_n1_start", W'(h_s[2][te+2]), W'(1));
        chk("E_n1_b", h_re[2][te+3], b_re);
        chk("E_n1_before", W'(h_v[2][te+1]), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
